uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Serial transmitter: the outbound counterpart of the uart_rx path on the DE0-Nano board.
- Accepts parallel words from on-chip logic (e.g. echo of received LCD text, status bytes) into a small FIFO.
- Serializes each word as 8N1 UART frames, LSB first, on a single output line.
- Sits in top beside uart_rx, sharing the board clock and the pkg DATA_BITS width.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (5208 at defaults).
- DATA_BITS, 8, word width, matches pkg DATA_BITS.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_data_tx  in  DATA_BITS  word to enqueue
- i_wr_tx  in  1  write strobe, one word per cycle high
- i_enb_tx  in  1  transmit enable; gates the start of new frames only
- o_full_tx  out  1  FIFO holds FIFO_DEPTH words
- o_empty_tx  out  1  FIFO holds 0 words
- o_ovf_tx  out  1  sticky overflow flag; cleared only by i_rst
- o_data_tx  out  1  serial line, idle high
- o_busy_tx  out  1  frame in progress (state not IDLE)
- o_done_tx  out  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset values: o_data_tx=1, o_busy_tx=0, o_done_tx=0, o_full_tx=0, o_empty_tx=1, o_ovf_tx=0. FIFO pointers and count are 0, state is IDLE, bit counter and baud counter are 0.
- Reset mid-frame aborts the frame: o_data_tx is 1 on the cycle after i_rst is sampled, and FIFO contents are discarded.
- FIFO write: when i_wr_tx=1 and o_full_tx=0, the word is stored at the write pointer and count increments.
- Write while full: the word is dropped and o_ovf_tx is set, even if a pop occurs in the same cycle. Count is unchanged except for that pop.
- Flags: o_full_tx and o_empty_tx are registered and derived from the count. They update the cycle after the write or pop.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: o_data_tx=1. If i_enb_tx=1 and o_empty_tx=0, pop the head word into the shift register and go to START.
  - A word written into an empty FIFO is not poppable until o_empty_tx has deasserted, so it starts at the earliest 2 cycles after the write.
- START: o_data_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: o_data_tx = shift register bit 0 for CLKS_PER_BIT cycles per bit. Shift right after each bit. After DATA_BITS bits go to STOP.
- STOP: o_data_tx=1 for CLKS_PER_BIT cycles. o_done_tx=1 on the final cycle. Then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
- Frame timing: a frame occupies exactly (DATA_BITS+2)*CLKS_PER_BIT cycles from the first start-bit cycle. Back-to-back frames are separated by exactly 1 IDLE cycle (line high).
- i_enb_tx falling mid-frame: the current frame completes normally; no new frame starts until i_enb_tx=1.
- Simultaneous write and pop on a non-full FIFO: both take effect and count is unchanged.
- o_busy_tx = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles. o_data_tx = XOR of the DATA_BITS data bits (even parity). Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 framing exactly as above.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10).
- Reset then idle 50 cycles -> o_data_tx=1, o_empty_tx=1, o_busy_tx=0, o_done_tx never pulses.
- Write 0xA5 with i_enb_tx=1 -> start bit low 10 cycles, then data bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high 10 cycles. o_done_tx pulses once, 100 cycles after the start edge.
- Write 0x00, 0xFF, 0x3C on consecutive cycles -> three frames in order, each 100 cycles, separated by exactly 1 high idle cycle. o_empty_tx=1 after the third pop.
- With i_enb_tx=0, write 17 words -> o_full_tx=1 after the 16th write, 17th word dropped, o_ovf_tx=1. Then raise i_enb_tx -> exactly 16 frames sent, in write order.
- Assert i_rst for 1 cycle at cycle 35 of a frame, with 3 words queued -> o_data_tx=1 next cycle, o_empty_tx=1, no further frames; o_ovf_tx cleared.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 for 10 cycles before stop, frame length 110 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO: queues parallel words and sends them as 8N1 frames, LSB first.
// Optional even parity bit before the stop bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data_tx,
  input  logic                 i_wr_tx,
  input  logic                 i_enb_tx,
  output logic                 o_full_tx,
  output logic                 o_empty_tx,
  output logic                 o_ovf_tx,
  output logic                 o_data_tx,
  output logic                 o_busy_tx,
  output logic                 o_done_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  // With one clock per bit the stop bit's only cycle is also its last.
  localparam logic DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

  // state  | meaning
  // IDLE   | line high, waiting for enable and a queued word
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | even parity bit (only with UART_TX_PARITY_EN)
  // STOP   | stop bit (high), done pulses on its last cycle
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       count_next;
  logic                 push;
  logic                 pop;

  always_comb begin
    push       = i_wr_tx && !o_full_tx;
    pop        = (state == IDLE) && i_enb_tx && !o_empty_tx;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data_tx;
  end

  // Flags are registered from the next count so they track it exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_full_tx  <= 1'b0;
      o_empty_tx <= 1'b1;
      o_ovf_tx   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (i_wr_tx && o_full_tx) o_ovf_tx <= 1'b1;
      count      <= count_next;
      o_full_tx  <= (count_next == DEPTH_CNT);
      o_empty_tx <= (count_next == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      o_data_tx <= 1'b1;
      o_busy_tx <= 1'b0;
      o_done_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      o_done_tx <= 1'b0;
      case (state)
        IDLE: begin
          o_data_tx <= 1'b1;
          o_busy_tx <= 1'b0;
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          if (pop) begin
            state     <= START;
            shift_reg <= mem[rd_ptr];
            o_data_tx <= 1'b0;
            o_busy_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity    <= ^mem[rd_ptr];
`endif
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            state     <= DATA;
            baud_cnt  <= '0;
            o_data_tx <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              o_data_tx <= parity;
`else
              state     <= STOP;
              o_data_tx <= 1'b1;
              o_done_tx <= DONE_ON_ENTRY;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              o_data_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            state     <= STOP;
            baud_cnt  <= '0;
            o_data_tx <= 1'b1;
            o_done_tx <= DONE_ON_ENTRY;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            o_data_tx <= 1'b1;
            o_busy_tx <= 1'b0;
          end else begin
            baud_cnt  <= baud_cnt + 1'b1;
            o_done_tx <= (baud_cnt == BAUD_PRE);
          end
        end
        default: begin
          state     <= IDLE;
          baud_cnt  <= '0;
          o_data_tx <= 1'b1;
          o_busy_tx <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes every frame against a queue of accepted
// words, plus a table of fixed frames and hand-written sequences for FIFO, enable and reset corners.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int CPB      = 10;
  localparam int DW       = 8;
  localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DW + 3;
`else
  localparam int FRAME_BITS = DW + 2;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_data_tx = '0;
  logic          i_wr_tx = 1'b0;
  logic          i_enb_tx = 1'b0;
  logic          o_full_tx, o_empty_tx, o_ovf_tx, o_data_tx, o_busy_tx, o_done_tx;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data_tx(i_data_tx), .i_wr_tx(i_wr_tx), .i_enb_tx(i_enb_tx),
    .o_full_tx(o_full_tx), .o_empty_tx(o_empty_tx), .o_ovf_tx(o_ovf_tx), .o_data_tx(o_data_tx),
    .o_busy_tx(o_busy_tx), .o_done_tx(o_done_tx)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected line level for bit slot pos of a frame carrying word w.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= DW) return w[pos-1];
    if (FRAME_BITS == DW + 3 && pos == DW + 1) return ^w;
    return 1'b1;
  endfunction

  // Reference model: words accepted into the FIFO, expected on the line in this order.
  logic [DW-1:0] exp_q[$];
  int            start_times[$];
  logic          start_empty[$];
  bit            mon_en = 1'b0;
  bit            mon_active = 1'b0;
  int            mon_idx, mon_bad;
  int            cyc = 0;
  int            stray_done = 0;
  logic [DW-1:0] mon_word, mon_rx;
  logic          mon_par = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (o_done_tx !== 1'b0) stray_done++;
        if (o_data_tx === 1'b0) begin
          mon_active = 1'b1;
          mon_idx = 0;
          mon_bad = 0;
          mon_rx = '0;
          chk("frame_expected", exp_q.size() != 0, 1);
          mon_word = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          start_times.push_back(cyc);
          start_empty.push_back(o_empty_tx);
        end
      end
      if (mon_active) begin
        if (o_data_tx !== exp_bit(mon_word, mon_idx / CPB) || o_busy_tx !== 1'b1 ||
            o_done_tx !== (mon_idx == FRAME_CYC - 1))
          mon_bad++;
        if (mon_idx % CPB == CPB / 2) begin
          if (mon_idx / CPB >= 1 && mon_idx / CPB <= DW) mon_rx[mon_idx/CPB-1] = o_data_tx;
          if (FRAME_BITS == DW + 3 && mon_idx / CPB == DW + 1) mon_par = o_data_tx;
        end
        mon_idx++;
        if (mon_idx == FRAME_CYC) begin
          mon_active = 1'b0;
          chk("frame_data", mon_rx, mon_word);
          chk("frame_wave_errs", mon_bad, 0);
        end
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [9:0]    bits;  // transmit order, first bit in the MSB
  } vec_t;
  vec_t tbl [8];

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || o_busy_tx !== 1'b0 || o_empty_tx !== 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", n < max, 1);
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    i_data_tx = w;
    i_wr_tx = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    i_wr_tx = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, tgt, cur, lat, n, s0, bad;
    logic [DW-1:0] w;
    logic [DW-1:0] b2b [3];

    tbl[0] = '{8'hA5, 10'b0_10100101_1};
    tbl[1] = '{8'h00, 10'b0_00000000_1};
    tbl[2] = '{8'hFF, 10'b0_11111111_1};
    tbl[3] = '{8'h3C, 10'b0_00111100_1};
    tbl[4] = '{8'h01, 10'b0_10000000_1};
    tbl[5] = '{8'h80, 10'b0_00000001_1};
    tbl[6] = '{8'h55, 10'b0_10101010_1};
    tbl[7] = '{8'hC4, 10'b0_00100011_1};
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;

    repeat (2) @(negedge clk);
    chk("rst_data", o_data_tx, 1);
    chk("rst_busy", o_busy_tx, 0);
    chk("rst_done", o_done_tx, 0);
    chk("rst_full", o_full_tx, 0);
    chk("rst_empty", o_empty_tx, 1);
    chk("rst_ovf", o_ovf_tx, 0);
    i_rst = 1'b0;
    i_enb_tx = 1'b1;
    mon_en = 1'b1;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_data_tx !== 1'b1 || o_busy_tx !== 1'b0 || o_done_tx !== 1'b0 || o_empty_tx !== 1'b1) bad++;
    end
    chk("idle_50", bad, 0);

    // Fixed frames sampled at bit centres, one at a time from idle.
    for (int i = 0; i < 8; i++) begin
      write_word(tbl[i].data);
      lat = 1;
      while (o_data_tx !== 1'b0 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("start_latency", lat, 2);
      cur = 0;
      for (int pos = 0; pos < 10; pos++) begin
        p = (pos == 9) ? FRAME_BITS - 1 : pos;
        tgt = p * CPB + CPB / 2;
        repeat (tgt - cur) @(negedge clk);
        cur = tgt;
        chk($sformatf("tbl%0d_bit%0d", i, pos), o_data_tx, tbl[i].bits[9-pos]);
      end
      repeat (FRAME_CYC - 1 - cur) @(negedge clk);
      chk("done_last_cycle", o_done_tx, 1);
      @(negedge clk);
      chk("done_clears", o_done_tx, 0);
      chk("busy_clears", o_busy_tx, 0);
    end

    // Three words on consecutive cycles: frames one idle cycle apart.
    s0 = start_times.size();
    for (int k = 0; k < 3; k++) begin
      i_data_tx = b2b[k];
      i_wr_tx = 1'b1;
      exp_q.push_back(b2b[k]);
      @(negedge clk);
    end
    i_wr_tx = 1'b0;
    n = 0;
    while (start_times.size() < s0 + 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_starts", start_times.size() - s0, 3);
    if (start_times.size() >= s0 + 3) begin
      chk("b2b_gap1", start_times[s0+1] - start_times[s0], FRAME_CYC + 1);
      chk("b2b_gap2", start_times[s0+2] - start_times[s0+1], FRAME_CYC + 1);
      chk("b2b_empty1", start_empty[s0], 0);
      chk("b2b_empty2", start_empty[s0+1], 0);
      chk("b2b_empty3", start_empty[s0+2], 1);
    end
    drain(4 * (FRAME_CYC + 1));

    // Fill with transmit disabled; 17th write coincides with the first pop and is still dropped.
    i_enb_tx = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("not_full_at_15", o_full_tx, 0);
      i_data_tx = DW'($urandom_range(0, 255));
      i_wr_tx = 1'b1;
      exp_q.push_back(i_data_tx);
      @(negedge clk);
    end
    chk("full_at_16", o_full_tx, 1);
    chk("ovf_before_17", o_ovf_tx, 0);
    chk("line_idle_disabled", o_data_tx, 1);
    s0 = start_times.size();
    i_data_tx = DW'($urandom_range(0, 255));
    i_wr_tx = 1'b1;
    i_enb_tx = 1'b1;
    @(negedge clk);
    i_wr_tx = 1'b0;
    chk("ovf_after_17", o_ovf_tx, 1);
    chk("full_after_pop", o_full_tx, 0);
    chk("frame_started", o_data_tx, 0);
    drain(16 * (FRAME_CYC + 1) + 100);
    chk("ovf_frames", start_times.size() - s0, 16);
    chk("ovf_sticky", o_ovf_tx, 1);

    // Enable dropped mid-frame: frame completes, next one waits.
    s0 = start_times.size();
    write_word(8'h5A);
    write_word(8'hC3);
    lat = 0;
    while (o_data_tx !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    repeat (30) @(negedge clk);
    i_enb_tx = 1'b0;
    repeat (FRAME_CYC + 100) @(negedge clk);
    chk("frames_while_disabled", start_times.size() - s0, 1);
    chk("busy_while_disabled", o_busy_tx, 0);
    chk("empty_while_disabled", o_empty_tx, 0);
    chk("line_while_disabled", o_data_tx, 1);
    i_enb_tx = 1'b1;
    drain(2 * (FRAME_CYC + 1) + 50);
    chk("frames_after_enable", start_times.size() - s0, 2);

    // Reset at cycle 35 of a frame with three words still queued.
    chk("ovf_before_reset", o_ovf_tx, 1);
    i_enb_tx = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_data_tx = DW'($urandom_range(0, 255));
      i_wr_tx = 1'b1;
      exp_q.push_back(i_data_tx);
      @(negedge clk);
    end
    i_wr_tx = 1'b0;
    i_enb_tx = 1'b1;
    lat = 0;
    while (o_data_tx !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("reset_frame_started", o_data_tx, 0);
    repeat (35) @(negedge clk);
    mon_en = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("rst_mid_data", o_data_tx, 1);
    chk("rst_mid_empty", o_empty_tx, 1);
    chk("rst_mid_ovf", o_ovf_tx, 0);
    chk("rst_mid_busy", o_busy_tx, 0);
    exp_q.delete();
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (o_data_tx !== 1'b1 || o_busy_tx !== 1'b0) bad++;
    end
    chk("no_frames_after_reset", bad, 0);
    mon_en = 1'b1;

    // Random bursts with enable toggling; never more than 12 outstanding.
    for (int b = 0; b < 6; b++) begin
      s0 = start_times.size();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 3)) begin
          i_enb_tx = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        w = DW'($urandom_range(0, 255));
        write_word(w);
      end
      i_enb_tx = 1'b1;
      drain(n * (FRAME_CYC + 1) + 200);
      chk("rand_frames", start_times.size() - s0, n);
    end

`ifdef UART_TX_PARITY_EN
    write_word(8'h07);
    drain(FRAME_CYC + 50);
    chk("parity_07", mon_par, 1);
    write_word(8'h03);
    drain(FRAME_CYC + 50);
    chk("parity_03", mon_par, 0);
`endif

    chk("final_ovf", o_ovf_tx, 0);
    chk("stray_done", stray_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
